// File: rtl/wb_pkg.sv
// Shared constants and stage-register type for the writeback stage and register file.
package wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_stage_t;

endpackage

// File: rtl/reg_array.sv
// NUM_REGS x DATA_W register array: one synchronous write port, two asynchronous read
// ports, synchronous clear; register 0 is hardwired to zero.
module reg_array
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != ZERO_REG)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata0 = (raddr0 == ZERO_REG) ? '0 : mem_q[raddr0];
    assign rdata1 = (raddr1 == ZERO_REG) ? '0 : mem_q[raddr1];

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB stage register, commit into the register array, and retired-writeback counter.
// Define WB_BYPASS_EN to forward the pending stage-register value onto the read ports.
module wb_regfile
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid_in,
    input  logic [ADDR_W-1:0] wb_dest_in,
    input  logic [DATA_W-1:0] wb_data_in,
    input  logic              wb_stall,
    input  logic              wb_flush,
    input  logic [ADDR_W-1:0] read_addr0,
    input  logic [ADDR_W-1:0] read_addr1,
    output logic [DATA_W-1:0] read_data0,
    output logic [DATA_W-1:0] read_data1,
    output logic              wb_pending,
    output logic [31:0]       retire_count
);

    wb_stage_t         stage_q, stage_d;
    logic [31:0]       retire_q, retire_d;
    logic              commit;
    logic [DATA_W-1:0] arr_rdata0, arr_rdata1;

    // Commit drains the current stage contents on the same edge that loads the next ones.
    always_comb begin
        stage_d  = stage_q;
        retire_d = retire_q;
        commit   = 1'b0;
        if (wb_flush) begin
            stage_d.valid = 1'b0;
        end else if (!wb_stall) begin
            commit  = stage_q.valid;
            stage_d = '{valid: wb_valid_in, dest: wb_dest_in, data: wb_data_in};
            if (stage_q.valid) begin
                retire_d = retire_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q  <= '0;
            retire_q <= '0;
        end else begin
            stage_q  <= stage_d;
            retire_q <= retire_d;
        end
    end

    reg_array u_reg_array (
        .clk    (clk),
        .reset  (reset),
        .we     (commit),
        .waddr  (stage_q.dest),
        .wdata  (stage_q.data),
        .raddr0 (read_addr0),
        .raddr1 (read_addr1),
        .rdata0 (arr_rdata0),
        .rdata1 (arr_rdata1)
    );

`ifdef WB_BYPASS_EN
    logic hit0, hit1;

    assign hit0 = stage_q.valid && (stage_q.dest != ZERO_REG) && (stage_q.dest == read_addr0);
    assign hit1 = stage_q.valid && (stage_q.dest != ZERO_REG) && (stage_q.dest == read_addr1);

    assign read_data0 = hit0 ? stage_q.data : arr_rdata0;
    assign read_data1 = hit1 ? stage_q.data : arr_rdata1;
`else
    assign read_data0 = arr_rdata0;
    assign read_data1 = arr_rdata1;
`endif

    assign wb_pending   = stage_q.valid;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected read/status values, a monitor
// pops and compares them on the falling edge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid_in;
    logic [4:0]  wb_dest_in;
    logic [31:0] wb_data_in;
    logic        wb_stall;
    logic        wb_flush;
    logic [4:0]  read_addr0;
    logic [4:0]  read_addr1;
    logic [31:0] read_data0;
    logic [31:0] read_data1;
    logic        wb_pending;
    logic [31:0] retire_count;

    typedef struct {
        string       name;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        pend;
        logic [31:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid_in  (wb_valid_in),
        .wb_dest_in   (wb_dest_in),
        .wb_data_in   (wb_data_in),
        .wb_stall     (wb_stall),
        .wb_flush     (wb_flush),
        .read_addr0   (read_addr0),
        .read_addr1   (read_addr1),
        .read_data0   (read_data0),
        .read_data1   (read_data1),
        .wb_pending   (wb_pending),
        .retire_count (retire_count)
    );

    // Monitor: one expectation is consumed per falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (read_data0 === e.exp0 && read_data1 === e.exp1 &&
                wb_pending === e.pend && retire_count === e.ret) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got rd0=%h rd1=%h pend=%b ret=%0d, want rd0=%h rd1=%h pend=%b ret=%0d",
                         e.name, read_data0, read_data1, wb_pending, retire_count,
                         e.exp0, e.exp1, e.pend, e.ret);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic pend, input logic [31:0] ret);
        exp_t e;
        read_addr0 = a0;
        read_addr1 = a1;
        e.name = name;
        e.exp0 = e0;
        e.exp1 = e1;
        e.pend = pend;
        e.ret  = ret;
        sb_q.push_back(e);
    endtask

    task automatic load(input logic [4:0] dest, input logic [31:0] data);
        wb_valid_in = 1'b1;
        wb_dest_in  = dest;
        wb_data_in  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        wb_valid_in = 1'b0;
        wb_dest_in  = '0;
        wb_data_in  = '0;
        wb_stall    = 1'b0;
        wb_flush    = 1'b0;
        read_addr0  = '0;
        read_addr1  = '0;
        step();
        step();
        check("reset_idle", 5'd5, 5'd31, 32'h0, 32'h0, 1'b0, 32'd0);
        reset = 1'b0;
        step();

        // Write r5 and observe stage then array.
        load(5'd5, 32'hDEADBEEF);
        step();
        wb_valid_in = 1'b0;
        check("wr5_edge1", 5'd5, 5'd0, Byp ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b1, 32'd0);
        step();
        check("wr5_edge2", 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 32'd1);
        step();

        // Write to r0 is dropped but still retires.
        load(5'd0, 32'h12345678);
        step();
        wb_valid_in = 1'b0;
        check("wr0_edge1", 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b1, 32'd1);
        step();
        check("wr0_edge2", 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 32'd2);
        step();

        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset2", 5'd5, 5'd0, 32'h0, 32'h0, 1'b0, 32'd0);
        step();

        // Stall three edges, then commit.
        load(5'd9, 32'hA5A5A5A5);
        step();
        wb_valid_in = 1'b0;
        wb_stall    = 1'b1;
        check("stall_load", 5'd9, 5'd0, Byp ? 32'hA5A5A5A5 : 32'h0, 32'h0, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_hold%0d", i), 5'd9, 5'd0,
                  Byp ? 32'hA5A5A5A5 : 32'h0, 32'h0, 1'b1, 32'd0);
        end
        wb_stall = 1'b0;
        step();
        check("stall_commit", 5'd9, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 32'd1);
        step();

        // Flush and stall together discard the pending write.
        load(5'd7, 32'h1);
        step();
        wb_valid_in = 1'b0;
        wb_flush    = 1'b1;
        wb_stall    = 1'b1;
        check("flush_pre", 5'd7, 5'd9, Byp ? 32'h1 : 32'h0, 32'hA5A5A5A5, 1'b1, 32'd1);
        step();
        wb_flush = 1'b0;
        wb_stall = 1'b0;
        check("flush_edge", 5'd7, 5'd9, 32'h0, 32'hA5A5A5A5, 1'b0, 32'd1);
        step();
        check("flush_after", 5'd7, 5'd9, 32'h0, 32'hA5A5A5A5, 1'b0, 32'd1);
        step();

        // Back-to-back writes to r3, then reset while the second is pending under stall.
        load(5'd3, 32'h11);
        step();
        load(5'd3, 32'h22);
        step();
        wb_valid_in = 1'b0;
        wb_stall    = 1'b1;
        check("b2b_pending", 5'd3, 5'd9, Byp ? 32'h22 : 32'h11, 32'hA5A5A5A5, 1'b1, 32'd2);
        step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        wb_stall = 1'b0;
        check("reset_mid_stall", 5'd3, 5'd9, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        step();

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            step();
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
